// File: rtl/bit_serializer_pkg.sv
// Shared types and sizing helpers for the bit_serializer slice.
package bit_serializer_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DIV   = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Upstream valid/ready word handshake into the serializer.
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/bit_serializer_strobe_gen.sv
// Mod-DIV prescaler: tick at count 0, wrap at count DIV-1.
module strobe_gen
    import bit_serializer_pkg::*;
#(
    parameter int unsigned DIV = DEF_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic wrap_o
);

    localparam int unsigned   CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);
    assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one ser_en strobe per bit, DIV cycles per bit.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned DIV       = DEF_DIV,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    bit_serializer_if.slave  in_if,
    output logic             ser_d,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned   BW    = cnt_w(WIDTH + 1);
    localparam logic [BW-1:0] NBITS = BW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ser_d_q, ser_d_d;
    logic             done_q, done_d;
    logic             accept, tick, wrap, last;

    assign in_if.in_ready = (state_q == IDLE) && !rst;
    assign accept         = in_if.in_valid && in_if.in_ready;

    strobe_gen #(.DIV(DIV)) u_strobe (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .en_i   (state_q == SHIFT),
        .tick_o (tick),
        .wrap_o (wrap)
    );

    // ser_d is loaded one edge ahead of each count-0 cycle so the bit and its
    // strobe appear together; the first bit comes straight from in_data.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        ser_d_d   = ser_d_q;
        done_d    = 1'b0;
        last      = (bit_cnt_q + BW'(tick)) == NBITS;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    if (MSB_FIRST) begin
                        ser_d_d = in_if.in_data[WIDTH-1];
                        sreg_d  = in_if.in_data << 1;
                    end else begin
                        ser_d_d = in_if.in_data[0];
                        sreg_d  = in_if.in_data >> 1;
                    end
                end
            end
            SHIFT: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (wrap) begin
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (MSB_FIRST) begin
                        ser_d_d = sreg_q[WIDTH-1];
                        sreg_d  = sreg_q << 1;
                    end else begin
                        ser_d_d = sreg_q[0];
                        sreg_d  = sreg_q >> 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            ser_d_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            ser_d_q   <= ser_d_d;
            done_q    <= done_d;
        end
    end

    assign ser_d  = ser_d_q;
    assign ser_en = (state_q == SHIFT) && tick;
    assign busy   = (state_q == SHIFT);
    assign done   = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: two serializer configurations plus a modelled downstream enabled flop.
module tb_bit_serializer;

    localparam int W     = 8;
    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    typedef struct {
        int   cyc;
        logic b;
    } strb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   vld = '0;
    logic [W-1:0] dat [2];
    logic [1:0]   rdy, s_d, s_en, s_busy, s_done;
    logic [1:0]   q_ff;

    bit_serializer_if #(.WIDTH(W)) if_a ();
    bit_serializer_if #(.WIDTH(W)) if_b ();

    assign if_a.in_valid = vld[0];
    assign if_a.in_data  = dat[0];
    assign rdy[0]        = if_a.in_ready;
    assign if_b.in_valid = vld[1];
    assign if_b.in_data  = dat[1];
    assign rdy[1]        = if_b.in_ready;

    bit_serializer #(.WIDTH(W), .DIV(DIV_A), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_if(if_a),
        .ser_d(s_d[0]), .ser_en(s_en[0]), .busy(s_busy[0]), .done(s_done[0])
    );

    bit_serializer #(.WIDTH(W), .DIV(DIV_B), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_if(if_b),
        .ser_d(s_d[1]), .ser_en(s_en[1]), .busy(s_busy[1]), .done(s_done[1])
    );

    // Downstream enabled D flop fed by ser_d / ser_en.
    always @(posedge clk) begin
        if (rst) q_ff <= '0;
        else     q_ff <= (s_en & s_d) | (~s_en & q_ff);
    end

    int checks = 0;
    int errors = 0;

    strb_t sq [2][$];
    int    dq [2][$];
    int    scnt [2];

    function automatic int div_of(input int i);
        return (i == 0) ? DIV_A : DIV_B;
    endfunction

    function automatic bit msb_of(input int i);
        return (i == 0);
    endfunction

    task automatic chk(input int id, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", id, name, act, exp, cyc);
        end
    endtask

    // Accept at edge e0: bit k strobes in cycle e0+1+k*DIV, done in e0+W*DIV+1.
    task automatic expect_word(input int i, input logic [W-1:0] w, input int e0);
        strb_t s;
        int d;
        int idx;
        d = div_of(i);
        for (int k = 0; k < W; k++) begin
            idx   = msb_of(i) ? (W - 1 - k) : k;
            s.cyc = e0 + 1 + k * d;
            s.b   = w[idx];
            sq[i].push_back(s);
        end
        dq[i].push_back(e0 + W * d + 1);
    endtask

    logic       rst_seen = 1'b1;
    logic [1:0] last_bit = '0;
    logic [1:0] lag_bit  = '0;
    always @(posedge clk) rst_seen <= rst;

    always @(negedge clk) begin
        strb_t s;
        int    exp_busy;
        for (int i = 0; i < 2; i++) begin
            if (rst_seen) begin
                sq[i].delete();
                dq[i].delete();
                last_bit[i] = 1'b0;
                lag_bit[i]  = 1'b0;
            end else begin
                chk(i, "flop_q", int'(q_ff[i]), int'(lag_bit[i]));

                exp_busy = (dq[i].size() != 0 && cyc >= dq[i][0] - W * div_of(i) && cyc < dq[i][0]) ? 1 : 0;
                chk(i, "busy", int'(s_busy[i]), exp_busy);

                if (s_en[i]) begin
                    scnt[i]++;
                    if (sq[i].size() == 0) begin
                        chk(i, "spurious_strobe", 1, 0);
                    end else begin
                        s = sq[i].pop_front();
                        chk(i, "strobe_cycle", cyc, s.cyc);
                        chk(i, "strobe_bit", int'(s_d[i]), int'(s.b));
                        last_bit[i] = s.b;
                    end
                end else if (sq[i].size() != 0 && sq[i][0].cyc <= cyc) begin
                    chk(i, "missed_strobe", 0, 1);
                    void'(sq[i].pop_front());
                end
                chk(i, "ser_d_level", int'(s_d[i]), int'(last_bit[i]));

                if (s_done[i]) begin
                    if (dq[i].size() == 0) chk(i, "spurious_done", 1, 0);
                    else                   chk(i, "done_cycle", cyc, dq[i].pop_front());
                end else if (dq[i].size() != 0 && dq[i][0] <= cyc) begin
                    chk(i, "missed_done", 0, 1);
                    void'(dq[i].pop_front());
                end
                lag_bit[i] = last_bit[i];
            end
        end
    end

    // Call at a falling edge; returns at the falling edge after the accept.
    task automatic send(input int i, input logic [W-1:0] w, output int e0);
        int t;
        t      = 0;
        vld[i] = 1'b1;
        dat[i] = w;
        while (!rdy[i] && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(i, "accept_in_time", int'(rdy[i]), 1);
        e0 = cyc;
        if (rdy[i]) expect_word(i, w, e0);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        chk(0, "in_ready_in_reset", int'(rdy[0]), 0);
        chk(1, "in_ready_in_reset", int'(rdy[1]), 0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk(i, {tag, "_ser_d"},  int'(s_d[i]),    0);
            chk(i, {tag, "_ser_en"}, int'(s_en[i]),   0);
            chk(i, {tag, "_busy"},   int'(s_busy[i]), 0);
            chk(i, {tag, "_done"},   int'(s_done[i]), 0);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (dq[0].size() != 0 || dq[1].size() != 0); t++) @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(i, "drain_strobes_left", sq[i].size(), 0);
            chk(i, "drain_done_left", dq[i].size(), 0);
        end
    endtask

    initial begin
        int e1, e2, e3, s0;
        logic [W-1:0] w;
        dat[0] = '0;
        dat[1] = '0;

        @(negedge clk);
        do_reset(4);
        check_quiet("after_reset");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk(0, "idle_in_ready", int'(rdy[0]), 1);
            chk(1, "idle_in_ready", int'(rdy[1]), 1);
            check_quiet("idle");
        end

        send(0, 8'hA5, e1);
        send(1, 8'h01, e2);
        drain();

        s0 = scnt[0];
        send(0, 8'hFF, e1);
        send(0, 8'h00, e2);
        chk(0, "b2b_accept_on_done", e2, e1 + W * DIV_A + 1);
        drain();
        chk(0, "b2b_strobe_total", scnt[0] - s0, 16);

        send(0, 8'hC3, e3);
        for (int t = 0; t < 100 && cyc != e3 + 1 + 2 * DIV_A; t++) @(negedge clk);
        chk(0, "third_strobe_seen", int'(s_en[0]), 1);
        do_reset(1);
        check_quiet("mid_reset");
        @(negedge clk);
        send(0, 8'h81, e1);
        drain();

        for (int n = 0; n < 12; n++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            w = W'($urandom);
            send(int'($urandom_range(1, 0)), w, e1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the enabled D flip-flop stage. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit at a time on `ser_d`, with a one-cycle `ser_en` strobe per bit. `ser_d` and `ser_en` connect directly to the downstream flop's `d` and `en`, which captures each bit on its strobe and holds it between strobes.

## Interface
- `WIDTH`, 8: bits per word; legal range 1 or more.
- `DIV`, 4: clock cycles per bit period; legal range 1 or more.
- `MSB_FIRST`, 1: 1 shifts `in_data[WIDTH-1]` first; 0 shifts `in_data[0]` first.

- `clk` input 1: clock, all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: upstream word available.
- `in_ready` output 1: block can accept a word.
- `in_data` input WIDTH: word to serialize, sampled only on accept.
- `ser_d` output 1: current serial bit, registered; feeds flop `d`.
- `ser_en` output 1: one-cycle strobe marking a new bit on `ser_d`; feeds flop `en`.
- `busy` output 1: high while a word is being shifted.
- `done` output 1: one-cycle pulse after the last bit period ends.

## Operation
- FSM states: IDLE and SHIFT.
- IDLE: `in_ready`=1. An accept is a rising edge with `in_valid`=1 and `in_ready`=1. On accept:
  - load the shift register with `in_data`;
  - clear the bit counter and the prescale counter;
  - go to SHIFT.
- SHIFT: `in_ready`=0, and `in_valid` is ignored.
  - The prescale counter counts 0..DIV-1.
  - At count 0, `ser_d` takes the next bit, `ser_en`=1, and the bit counter increments.
  - At all other counts, `ser_en`=0 and `ser_d` holds its value.
- Leaving SHIFT:
  - After bit WIDTH-1 completes its full DIV-cycle period, go to IDLE.
  - `done` pulses for one cycle, coincident with the first cycle of `in_ready`=1.
- Bit order:
  - MSB_FIRST=1: shift left, output the MSB.
  - MSB_FIRST=0: shift right, output the LSB.
- DIV=1: `ser_en` stays high for WIDTH consecutive cycles.
- `ser_d` is not cleared between words; it holds the last bit sent until the next word's first strobe.
- Reset mid-operation:
  - state returns to IDLE;
  - the word in progress is discarded;
  - all registered outputs clear;
  - no `done` pulse is generated.

## Timing
- Reset values: `ser_d`=0, `ser_en`=0, `busy`=0, `done`=0. `in_ready`=0 while `rst` is high, and 1 in the first cycle after reset deasserts.
- Let an accept occur at edge E0. Counting cycles after E0:
  - Bit k (0..WIDTH-1): `ser_en`=1 in cycle E0+1+k*DIV.
  - `busy`=1 in cycles E0+1 through E0+WIDTH*DIV inclusive.
  - `done`=1, `busy`=0, `in_ready`=1 in cycle E0+WIDTH*DIV+1.
- Latency from accept to first strobe: 1 cycle.
- Minimum spacing between accepts: WIDTH*DIV+1 cycles. A word presented with `in_valid` held high while `done` is pulsing is accepted at that edge.
- Exactly WIDTH strobes per word; none outside SHIFT.

## Structure
- Shared package: state typedef (IDLE, SHIFT) and counter-width helper constants derived from WIDTH and DIV using $clog2, minimum 1 bit each.
- Sub-module `strobe_gen`:
  - mod-DIV prescale counter with synchronous clear;
  - emits the count-0 tick used for `ser_en` and bit advance.
- Top level holds the FSM, shift register, bit counter and output registers.

## Test plan
- Reset, then idle 5 cycles: `in_ready`=1, `ser_en`=0, `busy`=0, `done`=0, `ser_d`=0.
- WIDTH=8, DIV=4, MSB_FIRST=1, accept 8'hA5:
  - `ser_en` high in cycles 1, 5, 9, …, 29 after accept;
  - `ser_d` sequence 1,0,1,0,0,1,0,1;
  - `done` at cycle 33.
- MSB_FIRST=0, DIV=1, accept 8'h01:
  - `ser_en` high for 8 consecutive cycles;
  - `ser_d` sequence 1,0,0,0,0,0,0,0;
  - `done` at cycle 9.
- Back-to-back: `in_valid` held high with 8'hFF then 8'h00:
  - second accept on the `done` cycle;
  - 16 strobes total;
  - `ser_d` holds 1 between the words.
- Assert `rst` at the 3rd bit strobe of 8'hC3:
  - next cycle: `busy`=0, `ser_en`=0, `ser_d`=0, no `done`;
  - a new word 8'h81 then serializes cleanly.
- Chain with the downstream flop (USE_EN=1): after each strobe, flop `q` equals the sent bit one cycle later, and holds between strobes.
